multi_wave_capture: RTL and testbench

//  Parametrised successor to the single-channel wave capture stage feeding the display RAM.

---
 rtl/multi_wave_capture.sv | 170 +++++++++++++++++
 tb/tb_multi_wave_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multi_wave_capture.sv
// -----------------------------------------------------------------------------
// multi_wave_capture
// Captures NCH audio channels in lock-step into ping-pong halves of per-channel
// sample RAMs. A programmable trigger (channel, level, slope) or free-run mode
// starts a capture of 2**(DEPTH-1) decimated samples into the half the display
// is not reading. The halves are swapped only while the display reports idle.
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-high reset
//   new_sample_ready  one-cycle strobe, new_sample_in valid
//   new_sample_in     packed signed samples, channel 0 in LSBs
//   trig_ch           trigger channel select (values >= NCH select channel 0)
//   trig_level        signed trigger threshold
//   trig_slope        0 = rising crossing, 1 = falling crossing
//   free_run          trigger on the first accepted sample while armed
//   decim             keep one of every decim+1 strobes
//   wave_display_idle display not reading RAM; buffer swap allowed
//   write_enable      per-channel RAM write strobe (all bits equal)
//   write_address     {~read_index, sample index}
//   write_sample      packed offset-binary samples, channel 0 in LSBs
//   read_index        buffer half the display must read
//   triggered         one-cycle pulse coinciding with the first write
// -----------------------------------------------------------------------------
module multi_wave_capture #(
    parameter int NCH     = 2,
    parameter int CH_W    = 1,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int DEPTH   = 9,
    parameter int DECIM_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_sample_ready,
    input  logic [NCH*IN_W-1:0]    new_sample_in,
    input  logic [CH_W-1:0]        trig_ch,
    input  logic signed [IN_W-1:0] trig_level,
    input  logic                   trig_slope,
    input  logic                   free_run,
    input  logic [DECIM_W-1:0]     decim,
    input  logic                   wave_display_idle,
    output logic [NCH-1:0]         write_enable,
    output logic [DEPTH-1:0]       write_address,
    output logic [NCH*OUT_W-1:0]   write_sample,
    output logic                   read_index,
    output logic                   triggered
);

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_ACTIVE,
        ST_WAIT
    } state_t;

    localparam logic [DEPTH-2:0]   IDX_ONE  = 1;
    localparam logic [DECIM_W-1:0] DCNT_ONE = 1;

    state_t                   r_state;
    logic [DEPTH-2:0]         r_idx;
    logic [DECIM_W-1:0]       r_dcnt;
    logic signed [IN_W-1:0]   r_prev;
    logic                     r_prev_valid;

    logic                     w_accept;
    logic signed [IN_W-1:0]   w_trig_cur;
    logic                     w_hit;
    logic [NCH*OUT_W-1:0]     w_conv;

    // Keep the top OUT_W bits and flip the sign bit: two's complement -> offset binary.
    function automatic logic [OUT_W-1:0] to_offset(input logic [IN_W-1:0] s);
        return {~s[IN_W-1], s[IN_W-2 -: OUT_W-1]};
    endfunction

    assign w_accept = new_sample_ready && (r_dcnt == '0);

    // Out-of-range channel selects fall back to channel 0.
    always_comb begin
        w_trig_cur = new_sample_in[IN_W-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (int'(trig_ch) == c) begin
                w_trig_cur = new_sample_in[c*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        w_conv = '0;
        for (int c = 0; c < NCH; c++) begin
            w_conv[c*OUT_W +: OUT_W] = to_offset(new_sample_in[c*IN_W +: IN_W]);
        end
    end

    // A crossing needs a previous accepted sample; the first one after reset never hits.
    always_comb begin
        if (trig_slope) begin
            w_hit = r_prev_valid && (r_prev >= trig_level) && (w_trig_cur < trig_level);
        end else begin
            w_hit = r_prev_valid && (r_prev < trig_level) && (w_trig_cur >= trig_level);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ARMED;
            r_idx         <= '0;
            r_dcnt        <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            write_enable  <= '0;
            write_address <= '0;
            write_sample  <= '0;
            read_index    <= 1'b0;
            triggered     <= 1'b0;
        end else begin
            write_enable <= '0;
            triggered    <= 1'b0;

            // Decimation counter runs on every strobe regardless of state.
            if (new_sample_ready) begin
                if (r_dcnt == '0) begin
                    r_dcnt <= decim;
                end else begin
                    r_dcnt <= r_dcnt - DCNT_ONE;
                end
            end

            if (w_accept) begin
                r_prev       <= w_trig_cur;
                r_prev_valid <= 1'b1;
            end

            case (r_state)
                ST_ARMED: begin
                    if (w_accept && (free_run || w_hit)) begin
                        write_enable  <= '1;
                        write_address <= {~read_index, {(DEPTH-1){1'b0}}};
                        write_sample  <= w_conv;
                        triggered     <= 1'b1;
                        r_idx         <= IDX_ONE;
                        r_state       <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept) begin
                        write_enable  <= '1;
                        write_address <= {~read_index, r_idx};
                        write_sample  <= w_conv;
                        if (&r_idx) begin
                            r_idx   <= '0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        r_state    <= ST_ARMED;
                    end
                end
                default: begin
                    r_state <= ST_ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_wave_capture.sv
module tb_multi_wave_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_sample_ready = 1'b0;
    logic [31:0] new_sample_in = '0;
    logic [0:0]  trig_ch = '0;
    logic signed [15:0] trig_level = '0;
    logic        trig_slope = 1'b0;
    logic        free_run = 1'b0;
    logic [3:0]  decim = '0;
    logic        wave_display_idle = 1'b0;
    logic [1:0]  write_enable;
    logic [8:0]  write_address;
    logic [15:0] write_sample;
    logic        read_index;
    logic        triggered;

    multi_wave_capture dut (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .trig_ch(trig_ch), .trig_level(trig_level),
        .trig_slope(trig_slope), .free_run(free_run), .decim(decim),
        .wave_display_idle(wave_display_idle), .write_enable(write_enable),
        .write_address(write_address), .write_sample(write_sample),
        .read_index(read_index), .triggered(triggered)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: capture phase (0 armed, 1 capturing, 2 waiting for display),
    // count of samples captured, strobes left to skip, last accepted trigger sample.
    int m_phase, m_cnt, m_skip, m_rd, m_prev, m_pv;
    int e_we, e_addr, e_smp, e_trig;

    function automatic int conv(input int x);
        return ((x + 32768) >> 8) & 255;
    endfunction

    function automatic int rnd_sample(input int span);
        return int'($urandom_range(0, 2*span)) - span;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("write_enable",  {30'd0, write_enable}, e_we);
        chk("write_address", {23'd0, write_address}, e_addr);
        chk("write_sample",  {16'd0, write_sample}, e_smp);
        chk("triggered",     {31'd0, triggered}, e_trig);
        chk("read_index",    {31'd0, read_index}, m_rd);
    endtask

    // Called at posedge+1; asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        m_phase = 0; m_cnt = 0; m_skip = 0; m_rd = 0; m_prev = 0; m_pv = 0;
        e_we = 0; e_addr = 0; e_smp = 0; e_trig = 0;
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_strobe(input int s0, input int s1);
        int cur, lvl;
        bit hit;
        new_sample_in    = {s1[15:0], s0[15:0]};
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        e_we = 0; e_trig = 0;
        if (m_skip == 0) begin
            m_skip = int'(decim);
            cur = (trig_ch == 1'b1) ? s1 : s0;
            lvl = trig_level;
            hit = (m_pv != 0) && (trig_slope ? (m_prev >= lvl && cur < lvl)
                                             : (m_prev < lvl && cur >= lvl));
            if (m_phase == 0 && (free_run || hit)) begin
                m_phase = 1; m_cnt = 0; e_trig = 1;
            end
            if (m_phase == 1) begin
                e_we   = 3;
                e_addr = (m_rd ? 0 : 256) + m_cnt;
                e_smp  = (conv(s1) << 8) | conv(s0);
                m_cnt++;
                if (m_cnt == 256) m_phase = 2;
            end
            m_prev = cur; m_pv = 1;
        end else begin
            m_skip--;
        end
        check_all();
    endtask

    task automatic idle_cycle(input bit idle);
        wave_display_idle = idle;
        @(posedge clk); #1;
        wave_display_idle = 1'b0;
        e_we = 0; e_trig = 0;
        if (idle && m_phase == 2) begin
            m_rd ^= 1; m_phase = 0;
        end
        check_all();
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Free-run capture of one full buffer into the upper half.
        free_run = 1'b1; decim = 4'd0;
        for (int i = 0; i < 256; i++) do_strobe(rnd_sample(32768) & 32'hFFFF_FFFF, rnd_sample(32767));
        for (int i = 0; i < 6; i++) do_strobe(rnd_sample(32767), rnd_sample(32767));
        idle_cycle(1'b0);
        chk("state_wait_no_write", {30'd0, write_enable}, 32'd0);

        // Idle pulse swaps halves; next capture fills the lower half.
        idle_cycle(1'b1);
        for (int i = 0; i < 256; i++) do_strobe(rnd_sample(32767), rnd_sample(32767));
        idle_cycle(1'b1);

        // Rising trigger on channel 1 at level 0.
        do_reset();
        free_run = 1'b0; trig_ch = 1'b1; trig_level = 16'sd0; trig_slope = 1'b0;
        do_strobe(rnd_sample(32767), -5);
        do_strobe(rnd_sample(32767), -1);
        do_strobe(rnd_sample(32767), 3);
        chk("rise_trig_pulse", {31'd0, triggered}, 32'd1);
        do_strobe(rnd_sample(32767), 7);

        // Falling trigger at 100; the first sample after reset must not trigger.
        do_reset();
        trig_ch = 1'b0; trig_level = 16'sd100; trig_slope = 1'b1;
        do_strobe(50, rnd_sample(32767));
        chk("first_sample_no_trig", {31'd0, triggered}, 32'd0);
        do_strobe(200, rnd_sample(32767));
        do_strobe(150, rnd_sample(32767));
        do_strobe(50, rnd_sample(32767));
        do_strobe(20, rnd_sample(32767));

        // Decimation by 4 with full-scale conversion extremes.
        do_reset();
        free_run = 1'b1; decim = 4'd3;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      do_strobe(-32768, 32767);
            else if (i == 4) do_strobe(32767, -32768);
            else             do_strobe(rnd_sample(32767), rnd_sample(32767));
        end

        // Reset in the middle of a capture, then restart at index 0.
        do_reset();
        decim = 4'd0;
        for (int i = 0; i < 40; i++) do_strobe(rnd_sample(32767), rnd_sample(32767));
        do_reset();
        do_strobe(rnd_sample(32767), rnd_sample(32767));
        chk("restart_addr", {23'd0, write_address}, 32'h100);

        // Randomised mix of strobes, idle pulses and control changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) begin
                trig_level = 16'(rnd_sample(3000));
                trig_slope = 1'($urandom_range(0, 1));
                trig_ch    = 1'($urandom_range(0, 1));
                decim      = 4'($urandom_range(0, 2));
                free_run   = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 9) < 8) do_strobe(rnd_sample(4000), rnd_sample(4000));
            else                          idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
